// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: sweeps coefficient addresses across all banks per sample
// strobe, forwards external coefficient writes, and paces the MAC lanes.
module fir_seq_ctrl #(
    parameter int P_NUM_TAP  = 10,
    parameter int P_NUM_BANK = 4,
    parameter int P_DATA_W   = 16,
    parameter int P_ADDR_W   = $clog2(P_NUM_TAP),
    parameter int P_BANK_W   = (P_NUM_BANK > 1) ? $clog2(P_NUM_BANK) : 1
) (
    input  logic                         iClk12M,
    input  logic                         iRsn,
    input  logic                         iEnSample600k,
    input  logic                         iCoeffUpdateFlag,
    input  logic                         iCsnRam,
    input  logic                         iWrnRam,
    input  logic [P_BANK_W+P_ADDR_W-1:0] iAddrRam,
    input  logic [P_DATA_W-1:0]          iWtDtRam,
    input  logic                         iClrOvr,
    output logic [P_NUM_BANK-1:0]        oCsnRam,
    output logic                         oWrnRam,
    output logic [P_ADDR_W-1:0]          oAddrRam,
    output logic [P_DATA_W-1:0]          oWtDtRam,
    output logic                         oEnDelay,
    output logic                         oClrAcc,
    output logic                         oEnMul,
    output logic                         oEnAddAcc,
    output logic                         oValid,
    output logic                         oBusy,
    output logic                         oOverrun
);

    typedef enum logic [2:0] {IDLE, UPDATE, RUN, DRAIN, OUT} state_t;

    localparam logic [P_ADDR_W-1:0] LAST_TAP = P_ADDR_W'(P_NUM_TAP - 1);

    state_t                state;
    logic [P_ADDR_W-1:0]   tap_cnt;
    logic                  drain_cnt;
    logic [P_BANK_W-1:0]   wr_bank;
    logic [P_ADDR_W-1:0]   wr_word;
    logic                  wr_ok;

    assign {wr_bank, wr_word} = iAddrRam;

    // Writes aimed at a nonexistent bank or word are silently dropped.
    assign wr_ok = (state == UPDATE) && iCoeffUpdateFlag && !iCsnRam && !iWrnRam &&
                   (int'(wr_bank) < P_NUM_BANK) && (int'(wr_word) < P_NUM_TAP);

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= 1'b0;
            oCsnRam   <= '1;
            oWrnRam   <= 1'b1;
            oAddrRam  <= '0;
            oWtDtRam  <= '0;
            oEnDelay  <= 1'b0;
            oClrAcc   <= 1'b0;
            oEnMul    <= 1'b0;
            oEnAddAcc <= 1'b0;
            oValid    <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oEnDelay  <= 1'b0;
            oClrAcc   <= 1'b0;
            oValid    <= 1'b0;
            oWrnRam   <= 1'b1;
            // RAM read latency is one cycle, the multiplier adds another.
            oEnMul    <= (state == RUN);
            oEnAddAcc <= oEnMul;

            if (iEnSample600k && state != IDLE) oOverrun <= 1'b1;
            else if (iClrOvr)                   oOverrun <= 1'b0;

            case (state)
                IDLE: begin
                    oCsnRam <= '1;
                    if (iCoeffUpdateFlag) begin
                        state <= UPDATE;
                        oBusy <= 1'b1;
                    end else if (iEnSample600k) begin
                        state    <= RUN;
                        tap_cnt  <= '0;
                        oAddrRam <= '0;
                        oCsnRam  <= '0;
                        oEnDelay <= 1'b1;
                        oClrAcc  <= 1'b1;
                        oBusy    <= 1'b1;
                    end
                end
                UPDATE: begin
                    oCsnRam <= '1;
                    if (wr_ok) begin
                        for (int b = 0; b < P_NUM_BANK; b++)
                            oCsnRam[b] <= (int'(wr_bank) != b);
                        oWrnRam  <= 1'b0;
                        oAddrRam <= wr_word;
                        oWtDtRam <= iWtDtRam;
                    end
                    if (!iCoeffUpdateFlag) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                end
                RUN: begin
                    if (tap_cnt == LAST_TAP) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                        oCsnRam   <= '1;
                    end else begin
                        tap_cnt  <= tap_cnt + 1'b1;
                        oAddrRam <= tap_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state  <= OUT;
                        oValid <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                OUT: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    oCsnRam <= '1;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl at N=10 taps, 4 banks, 16-bit coefficients.
module tb_fir_seq_ctrl;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strobe, flag, csn_in, wrn_in, clr_ovr;
    logic [5:0]  addr_in;
    logic [15:0] data_in;
    logic [3:0]  csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        en_delay, clr_acc, en_mul, en_add, valid, busy, overrun;

    int nvec = 0;
    int nerr = 0;

    fir_seq_ctrl dut (
        .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(strobe), .iCoeffUpdateFlag(flag),
        .iCsnRam(csn_in), .iWrnRam(wrn_in), .iAddrRam(addr_in), .iWtDtRam(data_in),
        .iClrOvr(clr_ovr), .oCsnRam(csn), .oWrnRam(wrn), .oAddrRam(addr), .oWtDtRam(data),
        .oEnDelay(en_delay), .oClrAcc(clr_acc), .oEnMul(en_mul), .oEnAddAcc(en_add),
        .oValid(valid), .oBusy(busy), .oOverrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".csn"}, csn, 4'hF);
        chk({tag, ".wrn"}, wrn, 1'b1);
        chk({tag, ".addr"}, addr, 4'h0);
        chk({tag, ".data"}, data, 16'h0);
        chk({tag, ".endly"}, en_delay, 1'b0);
        chk({tag, ".clracc"}, clr_acc, 1'b0);
        chk({tag, ".enmul"}, en_mul, 1'b0);
        chk({tag, ".enadd"}, en_add, 1'b0);
        chk({tag, ".valid"}, valid, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".ovr"}, overrun, 1'b0);
    endtask

    // Offset o counts cycles after the strobe-sampling edge; s2/fl inject a
    // second strobe / raise the update flag right after offset o is checked.
    task automatic sweep(input int s2, input int fl);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int o = 1; o <= N + 4; o++) begin
            if (o > 1) tick();
            chk("sw.csn", csn, (o <= N) ? 4'h0 : 4'hF);
            if (o <= N) chk("sw.addr", addr, o - 1);
            chk("sw.wrn", wrn, 1'b1);
            chk("sw.endly", en_delay, o == 1);
            chk("sw.clracc", clr_acc, o == 1);
            chk("sw.enmul", en_mul, (o >= 2) && (o <= N + 1));
            chk("sw.enadd", en_add, (o >= 3) && (o <= N + 2));
            chk("sw.valid", valid, o == N + 3);
            chk("sw.busy", busy, o <= N + 3);
            strobe = (o == s2);
            if (o == fl) flag = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; strobe = 1'b0; flag = 1'b0; csn_in = 1'b1; wrn_in = 1'b1;
        clr_ovr = 1'b0; addr_in = '0; data_in = '0;
        #12;
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_vals("idle");

        // plain sweep
        sweep(0, 0);

        // second strobe sampled 5 cycles after the first is dropped
        sweep(4, 0);
        chk("ovr.set", overrun, 1'b1);
        tick();
        chk("ovr.novalid", valid, 1'b0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr.clr", overrun, 1'b0);

        // coefficient update mode
        flag = 1'b1;
        tick();
        chk("upd.busy", busy, 1'b1);
        csn_in = 1'b0; wrn_in = 1'b0; addr_in = {2'd2, 4'd7}; data_in = 16'hA5A5;
        tick();
        chk("wr.csn", csn, 4'b1011);
        chk("wr.wrn", wrn, 1'b0);
        chk("wr.addr", addr, 4'd7);
        chk("wr.data", data, 16'hA5A5);
        addr_in = {2'd0, 4'd9}; data_in = 16'h1234;
        tick();
        chk("wr0.csn", csn, 4'b1110);
        chk("wr0.addr", addr, 4'd9);
        chk("wr0.data", data, 16'h1234);
        addr_in = {2'd1, 4'd12}; data_in = 16'hFFFF;
        tick();
        chk("oor.csn", csn, 4'hF);
        chk("oor.wrn", wrn, 1'b1);
        wrn_in = 1'b1; addr_in = {2'd3, 4'd1};
        tick();
        chk("rd.csn", csn, 4'hF);
        chk("rd.wrn", wrn, 1'b1);
        csn_in = 1'b1;
        // strobe during update with a simultaneous clear: the set wins
        strobe = 1'b1; clr_ovr = 1'b1;
        tick();
        strobe = 1'b0;
        chk("upd.ovr", overrun, 1'b1);
        chk("upd.nosweep", csn, 4'hF);
        tick();
        clr_ovr = 1'b0;
        chk("upd.clr", overrun, 1'b0);
        flag = 1'b0;
        tick();
        chk("upd.exit", busy, 1'b0);

        // flag and strobe together in idle: update wins, no overrun
        flag = 1'b1; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("pri.busy", busy, 1'b1);
        chk("pri.csn", csn, 4'hF);
        chk("pri.endly", en_delay, 1'b0);
        chk("pri.ovr", overrun, 1'b0);
        flag = 1'b0;
        tick();
        chk("pri.exit", busy, 1'b0);
        tick();
        chk("pri.nomul", en_mul, 1'b0);

        // flag rising mid-sweep is deferred until idle
        sweep(0, 3);
        chk("def.idle", busy, 1'b0);
        tick();
        chk("def.upd", busy, 1'b1);
        chk("def.csn", csn, 4'hF);
        flag = 1'b0;
        tick();
        chk("def.exit", busy, 1'b0);

        // asynchronous reset mid-sweep
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        chk("ar.pre", en_mul, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.idle", busy, 1'b0);
        chk("ar.csn", csn, 4'hF);
        sweep(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
